contador_programa: RTL and testbench

CONTADOR_PROGRAMA -- requirements
Module: contador_programa

---
 rtl/contador_programa.sv | 161 ++++++++++++++++
 tb/tb_contador_programa.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/contador_programa.sv
// contador_programa -- program counter for a MIPS-style fetch stage.
//
// Holds the current fetch address and advances it by 4 every cycle unless
// the pipeline is stalled or a redirect (taken branch or jump) arrives.
// A redirect that arrives while stalled is buffered and applied on the
// first non-stalled edge. Only word-aligned targets are accepted; a
// misaligned target is dropped and raises a sticky error flag.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hazard stall, pc holds while high
//   salto_valido   jump request from decode (one-cycle qualifier)
//   saltoNC        absolute jump target
//   rama_valida    taken-branch request from execute
//   rama_destino   branch target
//   pc             registered fetch address
//   pc4            pc + 4 (combinational)
//   pc4_alto       pc4[31:28], region bits for jump-target formation
//   flush          one-cycle kill of the wrong-path IF/ID instruction
//   pendiente      a redirect is buffered under stall
//   error_alin     sticky misaligned-target flag
//   cuenta_saltos  saturating count of applied redirects

module contador_programa #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        salto_valido,
  input  logic [31:0] saltoNC,
  input  logic        rama_valida,
  input  logic [31:0] rama_destino,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [3:0]  pc4_alto,
  output logic        flush,
  output logic        pendiente,
  output logic        error_alin,
  output logic [7:0]  cuenta_saltos
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  // Records whether the buffered target came from a jump; a younger jump
  // may only replace a buffered jump, never a buffered branch.
  logic        pend_salto_q, pend_salto_d;
  logic        flush_q, flush_d;
  logic        error_q, error_d;
  logic [7:0]  cuenta_q, cuenta_d;

  logic        rama_ok;
  logic        salto_ok;
  logic        desalineado;
  logic        aplicar;

  assign rama_ok     = rama_valida  && (rama_destino[1:0] == 2'b00);
  assign salto_ok    = salto_valido && (saltoNC[1:0]      == 2'b00);
  assign desalineado = (rama_valida  && (rama_destino[1:0] != 2'b00)) ||
                       (salto_valido && (saltoNC[1:0]      != 2'b00));

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    estado_d     = estado_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_salto_d = pend_salto_q;
    flush_d      = 1'b0;
    error_d      = error_q | desalineado;
    cuenta_d     = cuenta_q;
    aplicar      = 1'b0;

    unique case (estado_q)
      RUN: begin
        if (rama_ok || salto_ok) begin
          // The branch belongs to the older instruction, so it wins.
          if (stall) begin
            pend_d       = rama_ok ? rama_destino : saltoNC;
            pend_salto_d = !rama_ok;
            estado_d     = PEND;
          end else begin
            pc_d    = rama_ok ? rama_destino : saltoNC;
            aplicar = 1'b1;
          end
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end

      PEND: begin
        // Work out what the buffer would hold after this cycle's requests,
        // then either keep it (still stalled) or apply it.
        if (rama_ok) begin
          pend_d       = rama_destino;
          pend_salto_d = 1'b0;
        end else if (salto_ok && pend_salto_q) begin
          pend_d       = saltoNC;
          pend_salto_d = 1'b1;
        end

        if (!stall) begin
          pc_d         = pend_d;
          aplicar      = 1'b1;
          estado_d     = RUN;
          pend_d       = 32'h0000_0000;
          pend_salto_d = 1'b0;
        end
      end

      default: estado_d = RUN;
    endcase

    if (aplicar) begin
      flush_d = 1'b1;
      if (cuenta_q != 8'hFF) begin
        cuenta_d = cuenta_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  // NOTE: the pending-target register is reset too; a buffered redirect
  // must not survive reset, and its contents feed pc directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= RUN;
      pc_q         <= PC_RESET;
      pend_q       <= 32'h0000_0000;
      pend_salto_q <= 1'b0;
      flush_q      <= 1'b0;
      error_q      <= 1'b0;
      cuenta_q     <= 8'h00;
    end else begin
      estado_q     <= estado_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_salto_q <= pend_salto_d;
      flush_q      <= flush_d;
      error_q      <= error_d;
      cuenta_q     <= cuenta_d;
    end
  end

  assign pc            = pc_q;
  assign pc4           = pc_q + 32'd4;
  assign pc4_alto      = pc4[31:28];
  assign flush         = flush_q;
  assign pendiente     = (estado_q == PEND);
  assign error_alin    = error_q;
  assign cuenta_saltos = cuenta_q;

endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa -- directed self-checking bench for contador_programa.
// Each step drives inputs on the falling edge and pushes the expected
// post-edge state into a scoreboard; the entry is popped and compared
// just after the following rising edge.

module tb_contador_programa;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        salto_valido;
  logic [31:0] saltoNC;
  logic        rama_valida;
  logic [31:0] rama_destino;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [3:0]  pc4_alto;
  logic        flush;
  logic        pendiente;
  logic        error_alin;
  logic [7:0]  cuenta_saltos;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  contador_programa #(.PC_RESET(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .salto_valido  (salto_valido),
    .saltoNC       (saltoNC),
    .rama_valida   (rama_valida),
    .rama_destino  (rama_destino),
    .pc            (pc),
    .pc4           (pc4),
    .pc4_alto      (pc4_alto),
    .flush         (flush),
    .pendiente     (pendiente),
    .error_alin    (error_alin),
    .cuenta_saltos (cuenta_saltos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    logic [31:0] e_pc4;
    e_pc4 = e.pc + 32'd4;
    check({tag, ".pc"},        pc,                    e.pc);
    check({tag, ".pc4"},       pc4,                   e_pc4);
    check({tag, ".pc4_alto"},  {28'd0, pc4_alto},     {28'd0, e_pc4[31:28]});
    check({tag, ".flush"},     {31'd0, flush},        {31'd0, e.flush});
    check({tag, ".pendiente"}, {31'd0, pendiente},    {31'd0, e.pend});
    check({tag, ".error"},     {31'd0, error_alin},   {31'd0, e.err});
    check({tag, ".cuenta"},    {24'd0, cuenta_saltos}, {24'd0, e.cnt});
  endtask

  task automatic step(input string tag,
                      input logic st, input logic sv, input logic [31:0] snc,
                      input logic rv, input logic [31:0] rd,
                      input logic [31:0] e_pc, input logic e_fl, input logic e_pe,
                      input logic e_er, input logic [7:0] e_cn);
    exp_t e;
    exp_t got;
    @(negedge clk);
    stall        = st;
    salto_valido = sv;
    saltoNC      = snc;
    rama_valida  = rv;
    rama_destino = rd;
    e.pc = e_pc; e.flush = e_fl; e.pend = e_pe; e.err = e_er; e.cnt = e_cn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_state(tag, got);
  endtask

  initial begin
    exp_t r;
    logic [31:0] tgt;
    logic [7:0]  ecnt;

    rst_n = 1'b0; stall = 1'b0; salto_valido = 1'b0; saltoNC = '0;
    rama_valida = 1'b0; rama_destino = '0;
    r.pc = 32'h0; r.flush = 1'b0; r.pend = 1'b0; r.err = 1'b0; r.cnt = 8'h00;

    // Reset state, then sequential counting.
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", r);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("seq1", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0004, 0, 0, 0, 8'd0);
    step("seq2", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0008, 0, 0, 0, 8'd0);
    step("seq3", 0, 0, 32'h0, 0, 32'h0, 32'h0000_000C, 0, 0, 0, 8'd0);
    step("seq4", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0010, 0, 0, 0, 8'd0);

    // Jump without stall, flush for exactly one cycle.
    step("jump",      0, 1, 32'h0040_0020, 0, 32'h0, 32'h0040_0020, 1, 0, 0, 8'd1);
    step("jump_next", 0, 0, 32'h0,         0, 32'h0, 32'h0040_0024, 0, 0, 0, 8'd1);

    // Jump buffered under stall, then overwritten by a branch.
    step("pend_j",  1, 1, 32'h0000_0100, 0, 32'h0,         32'h0040_0024, 0, 1, 0, 8'd1);
    step("pend_b",  1, 0, 32'h0,         1, 32'h0000_0200, 32'h0040_0024, 0, 1, 0, 8'd1);
    step("pend_go", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 1, 0, 0, 8'd2);
    step("pend_nx", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0204, 0, 0, 0, 8'd2);

    // A buffered branch must not be replaced by a younger jump.
    step("keep_b",  1, 0, 32'h0,         1, 32'h0000_0280, 32'h0000_0204, 0, 1, 0, 8'd2);
    step("keep_j",  1, 1, 32'h0000_0500, 0, 32'h0,         32'h0000_0204, 0, 1, 0, 8'd2);
    step("keep_go", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0280, 1, 0, 0, 8'd3);
    step("keep_nx", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0284, 0, 0, 0, 8'd3);

    // Simultaneous branch and jump, then a back-to-back redirect.
    step("both",    0, 1, 32'h0000_0400, 1, 32'h0000_0300, 32'h0000_0300, 1, 0, 0, 8'd4);
    step("b2b",     0, 1, 32'h0000_0600, 0, 32'h0,         32'h0000_0600, 1, 0, 0, 8'd5);
    step("b2b_nx",  0, 0, 32'h0,         0, 32'h0,         32'h0000_0604, 0, 0, 0, 8'd5);

    // Misaligned branch: discarded, sticky error.
    step("mis",     0, 0, 32'h0, 1, 32'h0000_0302, 32'h0000_0608, 0, 0, 1, 8'd5);
    step("mis_nx",  0, 0, 32'h0, 0, 32'h0,         32'h0000_060C, 0, 0, 1, 8'd5);

    // Misaligned request while pending leaves the buffer unchanged.
    step("pmis_j",  1, 1, 32'h0000_0700, 0, 32'h0,         32'h0000_060C, 0, 1, 1, 8'd5);
    step("pmis_b",  1, 0, 32'h0,         1, 32'h0000_0702, 32'h0000_060C, 0, 1, 1, 8'd5);
    step("pmis_go", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0700, 1, 0, 1, 8'd6);

    // Many consecutive redirects: counter saturates at 0xFF.
    for (int i = 0; i < 300; i++) begin
      int c;
      tgt  = 32'h0001_0000 + 32'(i) * 32'd4;
      c    = 7 + i;
      ecnt = (c > 255) ? 8'hFF : 8'(c);
      step("sat", 0, 1, tgt, 0, 32'h0, tgt, 1, 0, 1, ecnt);
    end

    // Region bits and pc wraparound.
    step("alto",    0, 1, 32'hEFFF_FFFC, 0, 32'h0,         32'hEFFF_FFFC, 1, 0, 1, 8'hFF);
    step("top",     0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1, 8'hFF);
    step("wrap",    0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 0, 1, 8'hFF);
    step("wrap_nx", 0, 0, 32'h0,         0, 32'h0,         32'h0000_0004, 0, 0, 1, 8'hFF);

    // Reset mid-cycle while a redirect is pending.
    step("rp_pend", 1, 1, 32'h0000_0800, 0, 32'h0, 32'h0000_0004, 0, 1, 1, 8'hFF);
    #2;
    stall = 1'b0; salto_valido = 1'b0; saltoNC = '0;
    rst_n = 1'b0;
    #1;
    check_state("rst_async", r);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("rel1", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0004, 0, 0, 0, 8'd0);
    step("rel2", 0, 0, 32'h0, 0, 32'h0, 32'h0000_0008, 0, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
